// File: rtl/frame_capture_ctrl.sv
// Camera frame capture sequencer: synchronises the camera pins into the system
// clock domain and turns each valid pixel byte into one byte-wide memory write.
module frame_capture_ctrl #(
    parameter int ADDR_W   = 22,
    parameter int H_BYTES  = 1280,
    parameter int V_LINES  = 480,
    parameter int WR_PULSE = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        cameraD,
    input  logic              HSYNC,
    input  logic              VSYNC,
    input  logic              PXCLK,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              ce,
    output logic              wr,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int BC_W = $clog2(H_BYTES + 1);
    localparam int LC_W = $clog2(V_LINES + 1);
    localparam int PC_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [ADDR_W:0] ADDR_MAX    = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] FRAME_BYTES = (ADDR_W+1)'(H_BYTES * V_LINES);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
    state_t state, state_nx;

    // {cameraD, HSYNC, VSYNC, PXCLK} through two flops, plus one more for edges
    logic [10:0] sync1, sync2;
    logic        px_d, vs_d, hs_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            px_d  <= 1'b0;
            vs_d  <= 1'b0;
            hs_d  <= 1'b0;
        end else begin
            sync1 <= {cameraD, HSYNC, VSYNC, PXCLK};
            sync2 <= sync1;
            px_d  <= sync2[0];
            vs_d  <= sync2[1];
            hs_d  <= sync2[2];
        end
    end

    logic       px_s, vs_s, hs_s;
    logic [7:0] cam_s;
    logic       strobe, vs_fall, vs_rise, hs_fall;
    assign px_s    = sync2[0];
    assign vs_s    = sync2[1];
    assign hs_s    = sync2[2];
    assign cam_s   = sync2[10:3];
    assign strobe  = px_s & ~px_d & hs_s;
    assign vs_fall = ~vs_s & vs_d;
    assign vs_rise = vs_s & ~vs_d;
    assign hs_fall = ~hs_s & hs_d;

    logic [BC_W-1:0] byte_cnt;
    logic [LC_W-1:0] line_cnt;
    logic [PC_W-1:0] pulse_cnt;
    logic            vs_pend;
    logic            retire, last_wr, short_end, in_window, accept, ovf_hit, rearm;
    logic [ADDR_W:0] addr_nx;

    assign retire    = ce && (pulse_cnt == PC_W'(WR_PULSE - 1));
    assign addr_nx   = {1'b0, mem_addr} + 1'b1;
    assign last_wr   = retire && (addr_nx == FRAME_BYTES || addr_nx == ADDR_MAX);
    // a short frame still lets the write in flight retire before DONE
    assign short_end = (vs_rise || vs_pend) && (!ce || retire);
    assign in_window = (state == CAPTURE) && strobe && !vs_rise && !vs_pend &&
                       (byte_cnt < BC_W'(H_BYTES)) && (line_cnt < LC_W'(V_LINES));
    assign accept    = in_window && !ce;
    assign ovf_hit   = in_window && ce;
    assign rearm     = start && (state == IDLE || state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ARM;
            ARM:     if (vs_fall) state_nx = CAPTURE;
            CAPTURE: if (last_wr || short_end) state_nx = DONE;
            DONE:    if (start) state_nx = ARM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_data  <= '0;
            ce        <= 1'b0;
            overflow  <= 1'b0;
            byte_cnt  <= '0;
            line_cnt  <= '0;
            pulse_cnt <= '0;
            vs_pend   <= 1'b0;
        end else if (rearm) begin
            mem_addr <= '0;
            overflow <= 1'b0;
            byte_cnt <= '0;
            line_cnt <= '0;
            vs_pend  <= 1'b0;
        end else if (state == CAPTURE) begin
            if (hs_fall) begin
                byte_cnt <= '0;
                if (line_cnt != LC_W'(V_LINES)) line_cnt <= line_cnt + 1'b1;
            end else if (strobe && byte_cnt != BC_W'(H_BYTES)) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (vs_rise) vs_pend <= 1'b1;
            if (ovf_hit) overflow <= 1'b1;
            if (accept) begin
                mem_data  <= cam_s;
                ce        <= 1'b1;
                pulse_cnt <= '0;
            end else if (retire) begin
                ce <= 1'b0;
                if (addr_nx != ADDR_MAX + 1'b1) mem_addr <= addr_nx[ADDR_W-1:0];
            end else if (ce) begin
                pulse_cnt <= pulse_cnt + 1'b1;
            end
        end
    end

    assign wr   = ce;
    assign busy = (state == ARM) || (state == CAPTURE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: stimulus queues expected writes, a
// monitor pops them on each ce rising edge and checks address, data and pulse width.
module tb_frame_capture_ctrl;
    localparam int AW = 8;
    localparam int HB = 4;
    localparam int VL = 2;
    localparam int WP = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    cameraD = 8'h00;
    logic          HSYNC = 1'b0;
    logic          VSYNC = 1'b1;
    logic          PXCLK = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          ce, wr, busy, done, overflow;

    frame_capture_ctrl #(.ADDR_W(AW), .H_BYTES(HB), .V_LINES(VL), .WR_PULSE(WP)) dut (
        .clock(clock), .reset(reset), .start(start), .cameraD(cameraD),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .PXCLK(PXCLK),
        .mem_addr(mem_addr), .mem_data(mem_data), .ce(ce), .wr(wr),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int a, input int d);
        exp_q.push_back('{addr: AW'(a), data: 8'(d)});
    endtask

    task automatic monitor();
        logic          pce = 1'b0;
        int            width = 0;
        logic          moved = 1'b0;
        logic [AW-1:0] a0 = '0;
        wr_t           e;
        forever begin
            @(negedge clock);
            if (reset) begin
                pce = 1'b0;
                width = 0;
            end else begin
                if (ce && !pce) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL write: unexpected write addr %0h data %0h, none queued", mem_addr, mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_addr != e.addr || mem_data != e.data) begin
                            n_errors++;
                            $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                                     mem_addr, mem_data, e.addr, e.data);
                        end
                    end
                    check("wr_with_ce", int'(wr), 1);
                    a0 = mem_addr;
                    moved = 1'b0;
                    width = 1;
                end else if (ce) begin
                    width++;
                    if (mem_addr != a0) moved = 1'b1;
                end else if (pce) begin
                    check("pulse_width", width, WP);
                    check("addr_stable", int'(moved), 0);
                    check("wr_drop", int'(wr), 0);
                end
                pce = ce;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        PXCLK = 1'b0;
        cameraD = b;
        tick(2);
        PXCLK = 1'b1;
        tick(2);
    endtask

    task automatic fast_byte(input logic [7:0] b);
        PXCLK = 1'b0;
        cameraD = b;
        tick(1);
        PXCLK = 1'b1;
        tick(1);
    endtask

    task automatic line_start();
        HSYNC = 1'b1;
        tick(3);
    endtask

    task automatic line_end();
        HSYNC = 1'b0;
        tick(4);
    endtask

    task automatic frame_begin();
        pulse_start();
        tick(2);
        VSYNC = 1'b0;
        tick(5);
        line_start();
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && !done; i++) tick(1);
        check(name, int'(done), 1);
    endtask

    initial begin
        fork monitor(); join_none

        // reset state
        tick(2);
        check("rst_ce", int'(ce), 0);
        check("rst_wr", int'(wr), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_data", int'(mem_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b0;
        tick(2);

        // 1: reset during a write pulse
        frame_begin();
        push(0, 8'h5A);
        send_byte(8'h5A);
        for (int i = 0; i < 10 && !ce; i++) tick(1);
        check("t1_ce_seen", int'(ce), 1);
        #2 reset = 1'b1;
        #1;
        check("t1_ce", int'(ce), 0);
        check("t1_wr", int'(wr), 0);
        check("t1_addr", int'(mem_addr), 0);
        check("t1_busy", int'(busy), 0);
        check("t1_done", int'(done), 0);
        tick(1);
        reset = 1'b0;
        HSYNC = 1'b0;
        VSYNC = 1'b1;
        tick(4);
        check("t1_queue", exp_q.size(), 0);

        // 2: full 2x4 frame, with a stray byte while armed
        pulse_start();
        check("t2_busy_arm", int'(busy), 1);
        tick(2);
        line_start();
        send_byte(8'hEE);
        line_end();
        VSYNC = 1'b0;
        tick(5);
        for (int l = 0; l < 2; l++) begin
            line_start();
            for (int b = 0; b < 4; b++) begin
                push(l*4 + b, 8'h11 + l*4 + b);
                send_byte(8'(8'h11 + l*4 + b));
            end
            line_end();
        end
        wait_done("t2_done");
        check("t2_addr", int'(mem_addr), 8);
        check("t2_ovf", int'(overflow), 0);
        check("t2_busy", int'(busy), 0);
        check("t2_queue", exp_q.size(), 0);
        VSYNC = 1'b1;
        tick(4);

        // 3: short frame, VSYNC rises while the 5th write is in flight
        frame_begin();
        for (int b = 0; b < 4; b++) begin
            push(b, 8'h31 + b);
            send_byte(8'(8'h31 + b));
        end
        line_end();
        line_start();
        push(4, 8'h35);
        PXCLK = 1'b0;
        cameraD = 8'h35;
        tick(2);
        PXCLK = 1'b1;
        tick(1);
        VSYNC = 1'b1;
        wait_done("t3_done");
        check("t3_addr", int'(mem_addr), 5);
        check("t3_ovf", int'(overflow), 0);
        check("t3_queue", exp_q.size(), 0);
        line_end();

        // 4: bytes faster than the write pulse
        frame_begin();
        push(0, 8'hA1);
        push(1, 8'hA3);
        fast_byte(8'hA1);
        fast_byte(8'hA2);
        fast_byte(8'hA3);
        fast_byte(8'hA4);
        tick(2);
        line_end();
        VSYNC = 1'b1;
        wait_done("t4_done");
        check("t4_addr", int'(mem_addr), 2);
        check("t4_ovf", int'(overflow), 1);
        check("t4_queue", exp_q.size(), 0);
        tick(4);

        // 5: over-long line, overflow cleared by the new start
        frame_begin();
        check("t5_ovf_clr", int'(overflow), 0);
        for (int b = 0; b < 6; b++) begin
            if (b < 4) push(b, 8'hB1 + b);
            send_byte(8'(8'hB1 + b));
        end
        line_end();
        VSYNC = 1'b1;
        wait_done("t5_done");
        check("t5_addr", int'(mem_addr), 4);
        check("t5_ovf", int'(overflow), 0);
        check("t5_queue", exp_q.size(), 0);
        tick(4);

        // 6: start ignored mid-capture, honoured in DONE
        frame_begin();
        push(0, 8'hC1);
        push(1, 8'hC2);
        send_byte(8'hC1);
        send_byte(8'hC2);
        tick(6);
        pulse_start();
        tick(4);
        check("t6_busy_cap", int'(busy), 1);
        check("t6_done_cap", int'(done), 0);
        check("t6_addr_cap", int'(mem_addr), 2);
        line_end();
        VSYNC = 1'b1;
        wait_done("t6_done");
        check("t6_addr_done", int'(mem_addr), 2);
        pulse_start();
        check("t6_rearm_done", int'(done), 0);
        check("t6_rearm_busy", int'(busy), 1);
        check("t6_rearm_addr", int'(mem_addr), 0);
        tick(5);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
